seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (minimum 2).
- REQ-002: clk  input  1  rising-edge clock.
- REQ-003: rstn  input  1  reset, asynchronous, active-low.
- REQ-004: in_valid  input  1  dividend/divisor valid.
- REQ-005: in_ready  output  1  block idle, able to accept operands.
- REQ-006: dividend  input  WIDTH  numerator.
- REQ-007: divisor  input  WIDTH  denominator.
- REQ-008: out_valid  output  1  result valid.
- REQ-009: out_ready  input  1  consumer accepts result.
- REQ-010: quotient  output  WIDTH  division result.
- REQ-011: remainder  output  WIDTH  division remainder.
- REQ-012: div_by_zero  output  1  result came from a zero divisor.

Function
- REQ-013: The FSM SHALL have exactly three states: IDLE, CALC and DONE.
- REQ-014: in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
- REQ-015: An input handshake (in_valid & in_ready) SHALL latch both operands and move the FSM to CALC, or to DONE if divisor==0.
- REQ-016: CALC SHALL use restoring division, one quotient bit per cycle, MSB first: partial remainder P (WIDTH+1 bits) = {P[WIDTH-1:0], next dividend bit}; if P >= divisor, P -= divisor and the quotient bit is 1, else the quotient bit is 0.
- REQ-017: CALC SHALL last exactly WIDTH cycles, counted by a 0..WIDTH-1 iteration counter; after the final iteration the FSM SHALL move to DONE.
- REQ-018: Latency SHALL be fixed: out_valid asserts WIDTH+1 cycles after the input handshake edge for a nonzero divisor, and 1 cycle after it for a zero divisor.
- REQ-019: For divisor==0, the results SHALL be quotient = all ones, remainder = dividend, div_by_zero = 1.
- REQ-020: quotient, remainder and div_by_zero SHALL be registered and held stable while out_valid=1 && out_ready=0.
- REQ-021: An output handshake (out_valid & out_ready) SHALL return the FSM to IDLE; the next operands SHALL be accepted no earlier than the following cycle.
- REQ-022: in_valid SHALL be ignored outside IDLE.
- REQ-023: out_ready SHALL be ignored outside DONE.
- REQ-024: div_by_zero SHALL be cleared on the next accepted input.
- REQ-025: The invariant remainder < divisor SHALL hold in unsigned mode for every nonzero divisor.

Reset
- REQ-026: When rstn is asserted, the FSM SHALL go to IDLE and the counter, operand/partial registers, quotient, remainder and div_by_zero SHALL all be cleared to 0, so that in_ready=1 and out_valid=0.
- REQ-027: Reset during CALC or DONE SHALL abort the operation with no result produced.
- REQ-028: Operands SHALL NOT be accepted in the first clock after rstn is released if in_valid is low.

Configuration
- REQ-029: Macro SEQ_DIVIDER_SIGNED_EN: when defined, operands and results SHALL be two's complement and the division SHALL be performed on magnitudes.
- REQ-030: In signed mode, the quotient SHALL be negated when the operand signs differ, giving truncation toward zero.
- REQ-031: In signed mode, the remainder SHALL take the sign of the dividend.
- REQ-032: In signed mode, most-negative / -1 SHALL give quotient = most-negative value and remainder = 0.
- REQ-033: In signed mode, the sign fix SHALL be applied on the CALC->DONE edge, so latency is unchanged.
- REQ-034: When SEQ_DIVIDER_SIGNED_EN is undefined, all arithmetic SHALL be unsigned and no sign logic SHALL exist.
- REQ-035: Divide-by-zero results SHALL be identical in both builds (bit patterns as in REQ-019).

Structure
- REQ-036: Package seq_divider_pkg SHALL hold the state enum typedef (IDLE/CALC/DONE) and the default-width constant.
- REQ-037: Sub-module seq_div_step SHALL be combinational: it takes P, the next dividend bit and the divisor, and returns the next P and the quotient bit.
- REQ-038: seq_divider SHALL instantiate seq_div_step once.

Verification (WIDTH=4)
- REQ-039: 7/7 -> quotient=1, remainder=0, div_by_zero=0, out_valid exactly 5 cycles after the handshake.
- REQ-040: 13/4 -> quotient=3, remainder=1; 15/1 -> quotient=15, remainder=0; 3/9 -> quotient=0, remainder=3.
- REQ-041: 9/0 -> quotient=4'hF, remainder=9, div_by_zero=1, out_valid 1 cycle after the handshake.
- REQ-042: Hold out_ready=0 for 6 cycles in DONE -> outputs stable, in_ready=0 throughout; then drive in_valid with new operands in the out handshake cycle -> not accepted until IDLE.
- REQ-043: Assert rstn low on the 2nd CALC cycle -> in_ready=1, out_valid=0, outputs 0; a new 6/2 then gives quotient=3, remainder=0.
- REQ-044: With SEQ_DIVIDER_SIGNED_EN: -7/2 -> quotient=4'hD, remainder=4'hF; -8/-1 -> quotient=4'h8, remainder=0; 7/-2 -> quotient=4'hD, remainder=1.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state encoding and default width for seq_divider
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one combinational restoring-division iteration
module seq_div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   p,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // A set top bit of P would push the shifted value past any divisor,
  // so it forces a subtract even though the truncated trial looks small.
  always_comb begin
    trial = {p[WIDTH-1:0], dividend_bit};
    if (p[WIDTH] || (trial >= {1'b0, divisor})) begin
      p_next = trial - {1'b0, divisor};
      q_bit  = 1'b1;
    end else begin
      p_next = trial;
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider; SEQ_DIVIDER_SIGNED_EN selects two's complement operands
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   p;
  logic [WIDTH:0]   p_next;
  logic             q_bit;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_final, r_final;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg, r_neg;
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  // dvd doubles as the quotient accumulator: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  assign q_final = {dvd[WIDTH-2:0], q_bit};
  assign r_final = p_next[WIDTH-1:0];

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .p            (p),
    .dividend_bit (dvd[WIDTH-1]),
    .divisor      (dvs),
    .p_next       (p_next),
    .q_bit        (q_bit)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = (divisor == '0) ? DONE : CALC;
      CALC:    if (cnt == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      p           <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt         <= '0;
            p           <= '0;
            dvd         <= a_mag;
            dvs         <= b_mag;
            div_by_zero <= (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg       <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
            end
          end
        end
        CALC: begin
          p   <= p_next;
          dvd <= q_final;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            quotient  <= q_neg ? -q_final : q_final;
            remainder <= r_neg ? -r_final : r_final;
`else
            quotient  <= q_final;
            remainder <= r_final;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized scoreboard bench for seq_divider
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready, out_valid, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
    int           hs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hold_cnt = 0;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   qi, ri;
    e.hs = 0;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
      e.lat = 1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      int sa, sb_;
      sa  = $signed(a);
      sb_ = $signed(b);
      qi = sa / sb_;
      ri = sa % sb_;
`else
      int ua, ub;
      ua = a;
      ub = b;
      qi = ua / ub;
      ri = ua % ub;
`endif
      e.q = qi[W-1:0];
      e.r = ri[W-1:0];
      e.z = 1'b0;
      e.lat = W + 1;
    end
    return e;
  endfunction

  // Monitor and consumer: checks whatever the DUT presents, then decides out_ready.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got out_valid=1 expected no pending operation");
          out_ready = 1'b1;
        end else begin
          mon_e = sb[0];
          if (!prev_valid) check("latency", cyc - mon_e.hs + 1, mon_e.lat);
          check("quotient", quotient, mon_e.q);
          check("remainder", remainder, mon_e.r);
          check("div_by_zero", div_by_zero, mon_e.z);
          check("in_ready_in_done", in_ready, 0);
          if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
          end else begin
            out_ready = 1'($urandom_range(0, 1));
          end
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
      in_valid = 1'b0;
    end else begin
      e = model(a, b);
      e.hs = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_idle_clear(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_quotient"}, quotient, 0);
    check({tag, "_remainder"}, remainder, 0);
    check({tag, "_div_by_zero"}, div_by_zero, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle_clear("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Fixed cases with known answers
    send(4'd7, 4'd7);
    drain();
    send(4'd13, 4'd4);
    send(4'd15, 4'd1);
    send(4'd3, 4'd9);
    send(4'd9, 4'd0);
    drain();
`ifdef SEQ_DIVIDER_SIGNED_EN
    send(4'h9, 4'd2);
    send(4'h8, 4'hF);
    send(4'd7, 4'hE);
    drain();
`endif

    // Stall in DONE while the next operands are already being offered
    hold_cnt = 6;
    send(4'd13, 4'd4);
    send(4'd5, 4'd2);
    drain();

    // Reset in the second CALC cycle aborts the operation
    send(4'd11, 4'd3);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    sb.delete();
    #1;
    check_idle_clear("abort");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("no_accept_after_reset_in_ready", in_ready, 1);
    check("no_accept_after_reset_out_valid", out_valid, 0);
    send(4'd6, 4'd2);
    drain();

    // Random operands, including zero and boundary divisors
    for (int i = 0; i < 200; i++) begin
      send(W'($urandom), W'($urandom_range(0, 15)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
